color_gen: RTL and testbench

// - Drives 8-bit R/G/B channel codes for a requested colour class.
// - The classes are the set the colour classifier recognises: red, green, blue, purple and yellow, plus off.
// - Produces a stimulus/illumination source at the transmit end of the colour path.
// - Accepts one request at a time over a valid/ready handshake.
// - Optionally ramps the channels to the target, holds the target for a dwell time, then reports done.

---
 rtl/color_gen_if.sv | 9 +
 rtl/color_gen.sv | 143 ++++++++++++++
 tb/tb_color_gen.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/color_gen_if.sv
// Request channel of the colour generator: valid/ready handshake carrying a 3-bit colour class.
interface color_gen_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_color;

  modport master (output req_valid, output req_color, input req_ready);
  modport slave  (input req_valid, input req_color, output req_ready);
endinterface

// File: rtl/color_gen.sv
// Colour generator: drives 8-bit R/G/B codes for a requested colour class, holds them for DWELL edges.
// Define COLOR_GEN_RAMP_EN to ramp channels toward the target by at most STEP per edge before HOLD.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is
// high only in IDLE outside reset, and req_color is ignored on every other edge.
module color_gen #(
  parameter logic [7:0]  HI    = 8'd200,
  parameter logic [7:0]  LO    = 8'd20,
  parameter logic [7:0]  STEP  = 8'd8,
  parameter logic [15:0] DWELL = 16'd16
) (
  input  logic         clk,
  input  logic         rst_n,
  color_gen_if.slave   req,
  output logic [7:0]   r_out,
  output logic [7:0]   g_out,
  output logic [7:0]   b_out,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   state_dbg
);

`ifdef COLOR_GEN_RAMP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RAMP = 2'd1, S_HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_t;
`endif

  // A zero dwell still spends one edge in HOLD.
  localparam logic [15:0] DWELL_LAST = (DWELL == 16'd0) ? 16'd0 : DWELL - 16'd1;

  state_t      state, state_next;
  logic [7:0]  r_next, g_next, b_next;
  logic [15:0] hold_cnt, cnt_next;
  logic        done_next, err_next;
  logic        accept, legal;
  logic [23:0] tgt_req;

  function automatic logic [23:0] target_of(input logic [2:0] color);
    case (color)
      3'd1:    return {HI, LO, LO};
      3'd2:    return {LO, HI, LO};
      3'd3:    return {LO, LO, HI};
      3'd4:    return {HI, LO, HI};
      3'd5:    return {HI, HI, LO};
      default: return 24'd0;
    endcase
  endfunction

`ifdef COLOR_GEN_RAMP_EN
  logic [23:0] tgt, tgt_next;

  // Move one channel toward its target without overshoot or wrap.
  function automatic logic [7:0] step_to(input logic [7:0] cur, input logic [7:0] goal);
    if (cur < goal)      return ((goal - cur) > STEP) ? cur + STEP : goal;
    else if (cur > goal) return ((cur - goal) > STEP) ? cur - STEP : goal;
    else                 return cur;
  endfunction
`endif

  assign req.req_ready = (state == S_IDLE) && rst_n;
  assign accept        = req.req_valid && req.req_ready;
  assign legal         = (req.req_color <= 3'd5);
  assign tgt_req       = target_of(req.req_color);
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;

  always_comb begin
    state_next = state;
    r_next     = r_out;
    g_next     = g_out;
    b_next     = b_out;
    cnt_next   = hold_cnt;
    done_next  = 1'b0;
    err_next   = 1'b0;
`ifdef COLOR_GEN_RAMP_EN
    tgt_next   = tgt;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!legal) begin
            err_next = 1'b1;
          end else begin
`ifdef COLOR_GEN_RAMP_EN
            tgt_next   = tgt_req;
            state_next = S_RAMP;
`else
            {r_next, g_next, b_next} = tgt_req;
            state_next = S_HOLD;
`endif
          end
        end
      end
`ifdef COLOR_GEN_RAMP_EN
      S_RAMP: begin
        r_next = step_to(r_out, tgt[23:16]);
        g_next = step_to(g_out, tgt[15:8]);
        b_next = step_to(b_out, tgt[7:0]);
        if ({r_next, g_next, b_next} == tgt) state_next = S_HOLD;
      end
`endif
      S_HOLD: begin
        if (hold_cnt == DWELL_LAST) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
          cnt_next   = 16'd0;
        end else begin
          cnt_next = hold_cnt + 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      r_out    <= 8'd0;
      g_out    <= 8'd0;
      b_out    <= 8'd0;
      hold_cnt <= 16'd0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef COLOR_GEN_RAMP_EN
      tgt      <= 24'd0;
`endif
    end else begin
      state    <= state_next;
      r_out    <= r_next;
      g_out    <= g_next;
      b_out    <= b_next;
      hold_cnt <= cnt_next;
      done     <= done_next;
      err      <= err_next;
`ifdef COLOR_GEN_RAMP_EN
      tgt      <= tgt_next;
`endif
    end
  end

endmodule

// File: tb/tb_color_gen.sv
// Directed bench for color_gen (HI=200, LO=20, STEP=8); one DUT with DWELL=16, one with DWELL=0.
module tb_color_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] r, g, b, r0, g0, b0;
  logic       busy, done, err, busy0, done0, err0;
  logic [1:0] st, st0;
  int         total = 0;
  int         bad = 0;

  color_gen_if bus ();
  color_gen_if bus0 ();

  color_gen dut (
    .clk(clk), .rst_n(rst_n), .req(bus.slave),
    .r_out(r), .g_out(g), .b_out(b),
    .busy(busy), .done(done), .err(err), .state_dbg(st)
  );

  color_gen #(.DWELL(16'd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(bus0.slave),
    .r_out(r0), .g_out(g0), .b_out(b0),
    .busy(busy0), .done(done0), .err(err0), .state_dbg(st0)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_color  = 3'd1;
    bus0.req_valid = 1'b0;
    bus0.req_color = 3'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({r, g, b, busy, done, err} !== 27'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", {r, g, b, busy, done, err}, 27'd0);
    end
    total++;
    if ({st, st0, r0, g0, b0, busy0} !== 29'd0) begin
      bad++; $display("FAIL reset_dut0: got %h want %h", {st, st0, r0, g0, b0, busy0}, 29'd0);
    end
    total++;
    if (bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL ready_in_reset: got %b want 0", bus.req_ready);
    end
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_red();
    logic [1:0] exp_bd;
    @(negedge clk);
    bus.req_color = 3'd1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
`ifdef COLOR_GEN_RAMP_EN
    total++;
    if ({busy, r, g, b} !== {1'b1, 24'd0}) begin
      bad++; $display("FAIL red_accept: got %h want %h", {busy, r, g, b}, {1'b1, 24'd0});
    end
    for (int k = 1; k <= 25; k++) begin
      int er, eg;
      @(negedge clk);
      er = (8 * k > 200) ? 200 : 8 * k;
      eg = (8 * k > 20) ? 20 : 8 * k;
      total++;
      if ({r, g, b} !== {er[7:0], eg[7:0], eg[7:0]}) begin
        bad++; $display("FAIL red_ramp edge %0d: got %0d/%0d/%0d want %0d/%0d/%0d", k, r, g, b, er, eg, eg);
      end
    end
`else
    total++;
    if ({busy, r, g, b} !== {1'b1, 8'd200, 8'd20, 8'd20}) begin
      bad++; $display("FAIL red_load: got %0d %0d/%0d/%0d want 1 200/20/20", busy, r, g, b);
    end
`endif
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      exp_bd = (k == 16) ? 2'b01 : 2'b10;
      total++;
      if ({busy, done} !== exp_bd) begin
        bad++; $display("FAIL red_hold edge %0d busy/done: got %b want %b", k, {busy, done}, exp_bd);
      end
      total++;
      if ({r, g, b} !== {8'd200, 8'd20, 8'd20}) begin
        bad++; $display("FAIL red_hold edge %0d rgb: got %0d/%0d/%0d want 200/20/20", k, r, g, b);
      end
    end
    @(negedge clk);
    total++;
    if ({busy, done, r} !== {2'b00, 8'd200}) begin
      bad++; $display("FAIL red_idle: got %h want %h", {busy, done, r}, {2'b00, 8'd200});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    bus.req_color = 3'd1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    // Colour changes while busy must not be picked up.
    bus.req_color = 3'd2;
    n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ({done, bus.req_ready} !== 2'b11) begin
      bad++; $display("FAIL b2b_done_cycle done/ready: got %b want 11 after %0d cycles", {done, bus.req_ready}, n);
    end
    bus.req_color = 3'd5;
    @(negedge clk);
    bus.req_valid = 1'b0;
`ifdef COLOR_GEN_RAMP_EN
    total++;
    if ({busy, r, g, b} !== {1'b1, 8'd200, 8'd20, 8'd20}) begin
      bad++; $display("FAIL b2b_accept: got %0d %0d/%0d/%0d want 1 200/20/20", busy, r, g, b);
    end
    for (int k = 1; k <= 23; k++) begin
      int eg;
      @(negedge clk);
      eg = (20 + 8 * k > 200) ? 200 : 20 + 8 * k;
      total++;
      if ({r, g, b} !== {8'd200, eg[7:0], 8'd20}) begin
        bad++; $display("FAIL b2b_ramp edge %0d: got %0d/%0d/%0d want 200/%0d/20", k, r, g, b, eg);
      end
    end
`else
    total++;
    if ({busy, r, g, b} !== {1'b1, 8'd200, 8'd200, 8'd20}) begin
      bad++; $display("FAIL b2b_load: got %0d %0d/%0d/%0d want 1 200/200/20", busy, r, g, b);
    end
`endif
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 16) begin
      bad++; $display("FAIL b2b_hold_len: got %0d want 16", n);
    end
    total++;
    if ({done, r, g, b} !== {1'b1, 8'd200, 8'd200, 8'd20}) begin
      bad++; $display("FAIL b2b_final: got %0d %0d/%0d/%0d want 1 200/200/20", done, r, g, b);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    bus.req_color = 3'd7;
    bus.req_valid = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL illegal_ready_before: got %b want 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    total++;
    if ({err, busy, bus.req_ready} !== 3'b101) begin
      bad++; $display("FAIL illegal_err_cycle err/busy/ready: got %b want 101", {err, busy, bus.req_ready});
    end
    total++;
    if ({r, g, b} !== {8'd200, 8'd200, 8'd20}) begin
      bad++; $display("FAIL illegal_rgb: got %0d/%0d/%0d want 200/200/20", r, g, b);
    end
    @(negedge clk);
    total++;
    if ({err, busy} !== 2'b00) begin
      bad++; $display("FAIL illegal_after err/busy: got %b want 00", {err, busy});
    end
  endtask

  task automatic test_reset_mid_hold();
    int pulses;
    bus.req_color = 3'd3;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
`ifdef COLOR_GEN_RAMP_EN
    repeat (23 + 4) @(negedge clk);
`else
    repeat (4) @(negedge clk);
`endif
    total++;
    if ({busy, done, r, g, b} !== {2'b10, 8'd20, 8'd20, 8'd200}) begin
      bad++; $display("FAIL mid_hold_pre: got %0d%0d %0d/%0d/%0d want 10 20/20/200", busy, done, r, g, b);
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, err, r, g, b} !== 27'd0) begin
      bad++; $display("FAIL mid_hold_reset: got %h want 0", {busy, done, err, r, g, b});
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL mid_hold_ready: got %b want 1", bus.req_ready);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("FAIL mid_hold_no_done: got %0d want 0", pulses);
    end
  endtask

  task automatic test_dwell0();
    int bc, dc, exp_bc;
`ifdef COLOR_GEN_RAMP_EN
    exp_bc = 26;
`else
    exp_bc = 1;
`endif
    bus0.req_color = 3'd3;
    bus0.req_valid = 1'b1;
    @(negedge clk);
    bus0.req_valid = 1'b0;
    bc = 0;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) bc++;
      if (done0) dc++;
      @(negedge clk);
    end
    total++;
    if (bc !== exp_bc) begin
      bad++; $display("FAIL dwell0_busy_cycles: got %0d want %0d", bc, exp_bc);
    end
    total++;
    if (dc !== 1) begin
      bad++; $display("FAIL dwell0_done_pulses: got %0d want 1", dc);
    end
    total++;
    if ({err0, r0, g0, b0} !== {1'b0, 8'd20, 8'd20, 8'd200}) begin
      bad++; $display("FAIL dwell0_rgb: got %0d %0d/%0d/%0d want 0 20/20/200", err0, r0, g0, b0);
    end
  endtask

  initial begin
    test_reset();
    test_red();
    test_back_to_back();
    test_illegal();
    test_reset_mid_hold();
    test_dwell0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
